// File: rtl/acq_sequencer.sv
// acq_sequencer: capture sequencer (IDLE -> PRE -> ARMED -> POST -> DONE) over a circular sample RAM; AUTO_TRIG_TIMEOUT_EN adds the auto-trigger timeout.
// Latency: all outputs registered except Wr_En (combinational); trigger in ARMED reaches POST in one edge.
// Backpressure: none; CLK_EN paces every write and Stop aborts to IDLE from any state.
module acq_sequencer #(
    parameter int ADDR_W = 12,
    parameter int TMO_W  = 24
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              CLK_EN,
    input  logic              Start,
    input  logic              Stop,
    input  logic [ADDR_W-1:0] Pre_Depth,
    input  logic [ADDR_W-1:0] Post_Depth,
    input  logic              Trig_In,
    input  logic              Force_Trig,
    input  logic              Auto_Mode,
    input  logic [TMO_W-1:0]  Timeout,
    output logic              Start_Write,
    output logic              Enable_Trig,
    output logic              Wr_En,
    output logic [ADDR_W-1:0] Wr_Addr,
    output logic [ADDR_W-1:0] Trig_Addr,
    output logic              Busy,
    output logic              Done,
    output logic              Auto_Fired
);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_ARMED, S_POST, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] ONE_A = 1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pre_cnt, post_cnt;
    logic              pre_last, post_last, tmo_fire, trig_any;

    assign Wr_En     = CLK_EN && (state == S_PRE || state == S_ARMED || state == S_POST);
    // Depth 0 exits on the first cycle regardless of CLK_EN.
    assign pre_last  = (Pre_Depth == '0)  || (Wr_En && (pre_cnt + ONE_A == Pre_Depth));
    assign post_last = (Post_Depth == '0) || (Wr_En && (post_cnt + ONE_A == Post_Depth));
    assign trig_any  = Trig_In || Force_Trig || tmo_fire;

`ifdef AUTO_TRIG_TIMEOUT_EN
    localparam logic [TMO_W-1:0] ONE_T = 1;
    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_fire = (state == S_ARMED) && Auto_Mode &&
                      ((Timeout == '0) || (CLK_EN && (tmo_cnt + ONE_T == Timeout)));

    always_ff @(posedge CLK) begin
        if (!nRST)
            tmo_cnt <= '0;
        else if (state != S_ARMED)
            tmo_cnt <= '0;
        else if (Auto_Mode && CLK_EN)
            tmo_cnt <= tmo_cnt + ONE_T;
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{Auto_Mode, Timeout};
    assign tmo_fire   = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        if (Stop) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (Start)     state_nxt = S_PRE;
                S_PRE:          if (pre_last)  state_nxt = S_ARMED;
                S_ARMED:        if (trig_any)  state_nxt = S_POST;
                S_POST:         if (post_last) state_nxt = S_DONE;
                default:                       state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state       <= S_IDLE;
            pre_cnt     <= '0;
            post_cnt    <= '0;
            Wr_Addr     <= '0;
            Trig_Addr   <= '0;
            Start_Write <= 1'b0;
            Enable_Trig <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Auto_Fired  <= 1'b0;
        end else begin
            state       <= state_nxt;
            Start_Write <= state_nxt inside {S_PRE, S_ARMED, S_POST};
            Busy        <= state_nxt inside {S_PRE, S_ARMED, S_POST};
            Enable_Trig <= state_nxt inside {S_ARMED, S_POST};
            Done        <= (state_nxt == S_DONE);

            if (Wr_En)
                Wr_Addr <= Wr_Addr + ONE_A;
            if (state == S_PRE && Wr_En)
                pre_cnt <= pre_cnt + ONE_A;
            if (state == S_POST && Wr_En)
                post_cnt <= post_cnt + ONE_A;

            if (!Stop) begin
                if ((state == S_IDLE || state == S_DONE) && Start) begin
                    Wr_Addr    <= '0;
                    pre_cnt    <= '0;
                    post_cnt   <= '0;
                    Auto_Fired <= 1'b0;
                end
                // Trigger position is the address being written in the trigger cycle.
                if (state == S_ARMED && trig_any) begin
                    Trig_Addr <= Wr_Addr;
                    if (!Trig_In && !Force_Trig)
                        Auto_Fired <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer: a 12-bit instance for most scenarios and a 4-bit instance for address wrap.
module tb_acq_sequencer;
    localparam int AW  = 12;
    localparam int TW  = 24;
    localparam int AWS = 4;

    logic          CLK = 1'b0;
    logic          nRST, CLK_EN, Start, Stop, Trig_In, Force_Trig, Auto_Mode;
    logic [AW-1:0] Pre_Depth, Post_Depth;
    logic [TW-1:0] Timeout;
    logic          Start_Write, Enable_Trig, Wr_En, Busy, Done, Auto_Fired;
    logic [AW-1:0] Wr_Addr, Trig_Addr;

    logic [AWS-1:0] pre_s, post_s, wa_s, ta_s;
    logic           sw_s, et_s, we_s, busy_s, done_s, af_s;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    acq_sequencer #(.ADDR_W(AW), .TMO_W(TW)) dut (
        .CLK(CLK), .nRST(nRST), .CLK_EN(CLK_EN), .Start(Start), .Stop(Stop),
        .Pre_Depth(Pre_Depth), .Post_Depth(Post_Depth), .Trig_In(Trig_In),
        .Force_Trig(Force_Trig), .Auto_Mode(Auto_Mode), .Timeout(Timeout),
        .Start_Write(Start_Write), .Enable_Trig(Enable_Trig), .Wr_En(Wr_En),
        .Wr_Addr(Wr_Addr), .Trig_Addr(Trig_Addr), .Busy(Busy), .Done(Done),
        .Auto_Fired(Auto_Fired)
    );

    acq_sequencer #(.ADDR_W(AWS), .TMO_W(TW)) dut_s (
        .CLK(CLK), .nRST(nRST), .CLK_EN(CLK_EN), .Start(Start), .Stop(Stop),
        .Pre_Depth(pre_s), .Post_Depth(post_s), .Trig_In(Trig_In),
        .Force_Trig(Force_Trig), .Auto_Mode(Auto_Mode), .Timeout(Timeout),
        .Start_Write(sw_s), .Enable_Trig(et_s), .Wr_En(we_s),
        .Wr_Addr(wa_s), .Trig_Addr(ta_s), .Busy(busy_s), .Done(done_s),
        .Auto_Fired(af_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #2;
    endtask

    task automatic pulse_start;
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic pulse_stop;
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
    endtask

    int   wcount;
    int   exp_addr;
    logic en;
    bit   fin;

    initial begin
        nRST = 1'b0; CLK_EN = 1'b0; Start = 1'b0; Stop = 1'b0;
        Trig_In = 1'b0; Force_Trig = 1'b0; Auto_Mode = 1'b0; Timeout = '0;
        Pre_Depth = '0; Post_Depth = '0; pre_s = 4'd3; post_s = 4'd2;
        repeat (3) tick();
        chk("rst_ctl", {Start_Write, Enable_Trig, Wr_En, Busy, Done, Auto_Fired}, 0);
        chk("rst_wa", Wr_Addr, 0);
        chk("rst_ta", Trig_Addr, 0);
        chk("rst_wa_s", wa_s, 0);
        nRST = 1'b1;
        tick();

        // Basic capture: pre 4, post 8, trigger while writing address 10
        Pre_Depth = 12'd4; Post_Depth = 12'd8; CLK_EN = 1'b1;
        pulse_start();
        chk("t1_pre_sw", {Start_Write, Busy, Enable_Trig}, 3'b110);
        chk("t1_pre_wa", Wr_Addr, 0);
        repeat (3) tick();
        chk("t1_pre3_et", Enable_Trig, 0);
        tick();
        chk("t1_armed_et", Enable_Trig, 1);
        chk("t1_armed_wa", Wr_Addr, 4);
        repeat (6) tick();
        chk("t1_wa10", Wr_Addr, 10);
        Trig_In = 1'b1;
        tick();
        Trig_In = 1'b0;
        chk("t1_trig_addr", Trig_Addr, 10);
        chk("t1_post_wa", Wr_Addr, 11);
        repeat (7) tick();
        chk("t1_not_done", Done, 0);
        tick();
        chk("t1_done", {Done, Busy, Start_Write, Enable_Trig}, 4'b1000);
        chk("t1_done_wa", Wr_Addr, 19);
        chk("t1_done_we", Wr_En, 0);
        tick();
        chk("t1_frozen_wa", Wr_Addr, 19);

        // CLK_EN every 3rd cycle, pre 2, post 2, trigger on the 2nd armed sample
        Pre_Depth = 12'd2; Post_Depth = 12'd2;
        pulse_start();
        wcount = 0; exp_addr = 0; fin = 1'b0;
        for (int i = 0; i < 60 && !fin; i++) begin
            en      = (i % 3 == 0);
            CLK_EN  = en;
            Trig_In = (wcount == 0) || (wcount == 3 && en);
            #1;
            if (Busy && en) begin
                wcount++;
                exp_addr++;
            end
            tick();
            chk("t2_addr", Wr_Addr, exp_addr);
            if (Done) fin = 1'b1;
        end
        Trig_In = 1'b0;
        chk("t2_finished", fin, 1);
        chk("t2_writes", wcount, 6);
        chk("t2_trig_addr", Trig_Addr, 3);

        // 4-bit instance: wrap 15 -> 0, trigger after 20 writes
        CLK_EN = 1'b1;
        pulse_stop();
        Pre_Depth = 12'd3; Post_Depth = 12'd2;
        pulse_start();
        chk("t3_wa_s0", wa_s, 0);
        repeat (15) tick();
        chk("t3_wa_s15", wa_s, 15);
        tick();
        chk("t3_wrap", wa_s, 0);
        repeat (4) tick();
        Trig_In = 1'b1;
        tick();
        Trig_In = 1'b0;
        chk("t3_ta_s", ta_s, 4);
        chk("t3_big_ta", Trig_Addr, 20);
        repeat (2) tick();
        chk("t3_done_s", done_s, 1);
        chk("t3_wa_s_end", wa_s, 7);

        // Stop coincident with Trig_In while armed
        pulse_stop();
        Pre_Depth = 12'd1; Post_Depth = 12'd4;
        pulse_start();
        tick();
        chk("t4_armed", Enable_Trig, 1);
        Stop = 1'b1; Trig_In = 1'b1;
        tick();
        Stop = 1'b0; Trig_In = 1'b0;
        chk("t4_idle", {Start_Write, Enable_Trig, Busy, Done, Wr_En}, 0);
        chk("t4_ta_kept", Trig_Addr, 20);
        chk("t4_wa", Wr_Addr, 2);

        // Auto-trigger timeout 5
        Pre_Depth = 12'd1; Post_Depth = 12'd1; Auto_Mode = 1'b1; Timeout = 24'd5;
        pulse_start();
        tick();
        repeat (4) tick();
        chk("t5_wait_ta", Trig_Addr, 20);
        chk("t5_wait_af", Auto_Fired, 0);
        tick();
`ifdef AUTO_TRIG_TIMEOUT_EN
        chk("t5_fire_ta", Trig_Addr, 5);
        chk("t5_fire_af", Auto_Fired, 1);
        chk("t5_fire_wa", Wr_Addr, 6);
        tick();
        chk("t5_done", {Done, Auto_Fired}, 2'b11);
        pulse_stop();
        chk("t5_af_after_stop", Auto_Fired, 1);
`else
        chk("t5_noauto_ta", Trig_Addr, 20);
        repeat (20) tick();
        chk("t5_noauto_state", {Done, Enable_Trig, Busy, Auto_Fired}, 4'b0110);
        chk("t5_noauto_wa", Wr_Addr, 26);
        pulse_stop();
`endif

        // Zero depths with a Force_Trig pulse, CLK_EN held low
        Auto_Mode = 1'b0; CLK_EN = 1'b0; Pre_Depth = '0; Post_Depth = '0;
        pulse_start();
        chk("t6_pre", {Start_Write, Enable_Trig, Busy, Auto_Fired}, 4'b1010);
        chk("t6_pre_wa", Wr_Addr, 0);
        tick();
        chk("t6_armed_et", Enable_Trig, 1);
`ifdef AUTO_TRIG_TIMEOUT_EN
        chk("t6_armed_ta", Trig_Addr, 5);
`else
        chk("t6_armed_ta", Trig_Addr, 20);
`endif
        Force_Trig = 1'b1;
        tick();
        Force_Trig = 1'b0;
        chk("t6_post_ta", Trig_Addr, 0);
        chk("t6_post", {Done, Busy}, 2'b01);
        tick();
        chk("t6_done", {Done, Busy, Start_Write}, 3'b100);

        // Real trigger coincident with timeout 0 expiry
        pulse_stop();
        Auto_Mode = 1'b1; Timeout = '0;
        pulse_start();
        tick();
        Trig_In = 1'b1;
        tick();
        Trig_In = 1'b0;
        chk("t7_af_real_wins", Auto_Fired, 0);
        tick();
        chk("t7_done", Done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
